nnrv_regdump: RTL and testbench

// - Synthesizable successor to the fixed-delay bench dump: after a cycle timeout or a halt event, scans the core register file out as a word stream.
// - Sits beside nnrv_top and taps a spare register-file read port.
// - Lets the same dump run in simulation and on FPGA, where a UART or LED sink consumes the stream.
// - Adds over the bench: parametrised count/width/grouping, halt trigger, backpressure, re-arm.

---
 rtl/nnrv_pkg.sv | 20 ++
 rtl/nnrv_regdump_if.sv | 33 +++
 rtl/nnrv_dump_timer.sv | 37 +++
 rtl/nnrv_regdump.sv | 149 ++++++++++++++
 tb/tb_nnrv_regdump.sv | 244 ++++++++++++++++++++++++
 5 files changed

// File: rtl/nnrv_pkg.sv
// Shared types and defaults for the register-dump block.
// The state encoding and the line-start helper are used by both the RTL and the sink side.
package nnrv_pkg;

   localparam int NNRV_XLEN  = 32;
   localparam int NNRV_NREGS = 32;

   typedef enum logic [1:0] {
      ST_ARM  = 2'd0,
      ST_RD   = 2'd1,
      ST_OUT  = 2'd2,
      ST_DONE = 2'd3
   } dump_state_e;

   // A dump line starts on every GROUP-th register index.
   function automatic logic is_line_start(input int idx, input int group);
      return (idx % group) == 0;
   endfunction

endpackage

// File: rtl/nnrv_regdump_if.sv
// Valid/ready word stream carrying one dumped register per transfer.
// The idx/sol/last sideband travels with data and is meaningful only while valid is high.
interface nnrv_regdump_if
   import nnrv_pkg::*;
#(
   parameter int XLEN  = NNRV_XLEN,
   parameter int IDX_W = $clog2(NNRV_NREGS)
);
   logic             valid;
   logic             ready;
   logic [XLEN-1:0]  data;
   logic [IDX_W-1:0] idx;
   logic             sol;
   logic             last;

   modport master (
      output valid,
      output data,
      output idx,
      output sol,
      output last,
      input  ready
   );

   modport slave (
      input  valid,
      input  data,
      input  idx,
      input  sol,
      input  last,
      output ready
   );
endinterface

// File: rtl/nnrv_dump_timer.sv
// Saturating arm timer: counts while enabled, stops at TIMEOUT-1 so it can fire once per arm.
// TIMEOUT=0 disables the timer entirely (counter parked at zero, hit never asserted).
module nnrv_dump_timer #(
   parameter int TIMEOUT = 300,
   parameter int CNT_W   = 16
)(
   input  logic i_clk,
   input  logic i_rst,
   input  logic i_clr,
   input  logic i_en,
   output logic o_hit
);
   localparam logic [CNT_W-1:0] HIT_VAL = CNT_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (i_clr) begin
         cnt_d = '0;
      end else if (i_en && (TIMEOUT != 0) && (cnt_q != HIT_VAL)) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign o_hit = (TIMEOUT != 0) && (cnt_q == HIT_VAL);

endmodule

// File: rtl/nnrv_regdump.sv
// Register-file dump engine: on halt or timeout, streams registers 0..NREGS-1 over a
// valid/ready word interface, one word every two cycles, then idles until re-armed.
module nnrv_regdump
   import nnrv_pkg::*;
#(
   parameter int XLEN    = NNRV_XLEN,
   parameter int NREGS   = NNRV_NREGS,
   parameter int GROUP   = 8,
   parameter int TIMEOUT = 300,
   parameter int CNT_W   = 16,
   localparam int IDX_W  = $clog2(NREGS)
)(
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              i_halt,
   input  logic              i_rearm,
   output logic [IDX_W-1:0]  o_rf_addr,
   input  logic [XLEN-1:0]   i_rf_data,
   nnrv_regdump_if.master    dump,
   output logic              o_busy,
   output logic              o_done
);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NREGS - 1);

   dump_state_e      state_q,   state_d;
   logic [IDX_W-1:0] idx_q,     idx_d;
   logic [IDX_W-1:0] rf_addr_q, rf_addr_d;
   logic             valid_q,   valid_d;
   logic [XLEN-1:0]  data_q,    data_d;
   logic [IDX_W-1:0] out_idx_q, out_idx_d;
   logic             sol_q,     sol_d;
   logic             last_q,    last_d;
   logic             busy_q,    busy_d;
   logic             done_q,    done_d;

   logic timer_clr;
   logic timer_en;
   logic timer_hit;
   logic idx_is_last;

   nnrv_dump_timer #(
      .TIMEOUT (TIMEOUT),
      .CNT_W   (CNT_W)
   ) u_timer (
      .i_clk   (i_clk),
      .i_rst   (i_rst),
      .i_clr   (timer_clr),
      .i_en    (timer_en),
      .o_hit   (timer_hit)
   );

   assign idx_is_last = (idx_q == LAST_IDX);

   always_comb begin
      state_d   = state_q;
      idx_d     = idx_q;
      rf_addr_d = rf_addr_q;
      valid_d   = valid_q;
      data_d    = data_q;
      out_idx_d = out_idx_q;
      sol_d     = sol_q;
      last_d    = last_q;
      timer_clr = 1'b0;
      timer_en  = 1'b0;

      unique case (state_q)
         ST_ARM: begin
            timer_en = 1'b1;
            if (i_halt || timer_hit) begin
               state_d = ST_RD;
            end
         end

         ST_RD: begin
            valid_d   = 1'b1;
            data_d    = i_rf_data;
            out_idx_d = idx_q;
            sol_d     = is_line_start(int'(idx_q), GROUP);
            last_d    = idx_is_last;
            // Address runs one register ahead so a registered-read RF has the
            // next word ready by the following RD cycle; parks at 0 after the last.
            rf_addr_d = idx_is_last ? '0 : idx_q + 1'b1;
            state_d   = ST_OUT;
         end

         ST_OUT: begin
            if (valid_q && dump.ready) begin
               valid_d = 1'b0;
               if (last_q) begin
                  idx_d   = '0;
                  state_d = ST_DONE;
               end else begin
                  idx_d   = idx_q + 1'b1;
                  state_d = ST_RD;
               end
            end
         end

         ST_DONE: begin
            if (i_rearm) begin
               timer_clr = 1'b1;
               idx_d     = '0;
               state_d   = ST_ARM;
            end
         end

         default: state_d = ST_ARM;
      endcase

      busy_d = (state_d == ST_RD) || (state_d == ST_OUT);
      done_d = (state_d == ST_DONE);
   end

   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
         state_q   <= ST_ARM;
         idx_q     <= '0;
         rf_addr_q <= '0;
         valid_q   <= 1'b0;
         data_q    <= '0;
         out_idx_q <= '0;
         sol_q     <= 1'b0;
         last_q    <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         idx_q     <= idx_d;
         rf_addr_q <= rf_addr_d;
         valid_q   <= valid_d;
         data_q    <= data_d;
         out_idx_q <= out_idx_d;
         sol_q     <= sol_d;
         last_q    <= last_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
      end
   end

   assign o_rf_addr  = rf_addr_q;
   assign dump.valid = valid_q;
   assign dump.data  = data_q;
   assign dump.idx   = out_idx_q;
   assign dump.sol   = sol_q;
   assign dump.last  = last_q;
   assign o_busy     = busy_q;
   assign o_done     = done_q;

endmodule

// File: tb/tb_nnrv_regdump.sv
// Bench for nnrv_regdump: two instances (32x32b/GROUP 8/TIMEOUT 20 and 20x64b/GROUP 5/no timer)
// checked every cycle against an expected-index sequence model plus literal timing/count pins.
module tb_nnrv_regdump;

   logic        clk;
   logic        rst_a, rst_b;
   logic        halt_a, halt_b;
   logic        rearm_a, rearm_b;
   logic [4:0]  rf_addr_a, rf_addr_b;
   logic [31:0] rf_data_a;
   logic [63:0] rf_data_b;
   logic        busy_a, done_a, busy_b, done_b;

   nnrv_regdump_if #(.XLEN(32), .IDX_W(5)) ifa ();
   nnrv_regdump_if #(.XLEN(64), .IDX_W(5)) ifb ();

   nnrv_regdump #(.XLEN(32), .NREGS(32), .GROUP(8), .TIMEOUT(20), .CNT_W(16)) dut_a (
      .i_clk(clk), .i_rst(rst_a), .i_halt(halt_a), .i_rearm(rearm_a),
      .o_rf_addr(rf_addr_a), .i_rf_data(rf_data_a), .dump(ifa.master),
      .o_busy(busy_a), .o_done(done_a)
   );

   nnrv_regdump #(.XLEN(64), .NREGS(20), .GROUP(5), .TIMEOUT(0), .CNT_W(16)) dut_b (
      .i_clk(clk), .i_rst(rst_b), .i_halt(halt_b), .i_rearm(rearm_b),
      .o_rf_addr(rf_addr_b), .i_rf_data(rf_data_b), .dump(ifb.master),
      .o_busy(busy_b), .o_done(done_b)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Registered-read register files: data for an address appears one cycle later.
   always @(posedge clk) begin
      rf_data_a <= 32'hA000_0000 + 32'(rf_addr_a);
      rf_data_b <= 64'hC0DE_F00D_A000_0000 + 64'(rf_addr_b);
   end

   // Cycle labels: the last edge seen with reset low is cycle 1.
   int cyc [2] = '{0, 0};
   always @(posedge clk) begin
      cyc[0] <= rst_a ? cyc[0] + 1 : 1;
      cyc[1] <= rst_b ? cyc[1] + 1 : 1;
   end

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   // Reference model state per instance.
   int          nregs     [2] = '{32, 20};
   int          grp       [2] = '{8, 5};
   logic [63:0] base      [2] = '{64'hA000_0000, 64'hC0DE_F00D_A000_0000};
   int          exp_idx   [2] = '{0, 0};
   bit          stalled   [2] = '{0, 0};
   logic [63:0] hold_data [2];
   int          hold_idx  [2];
   int          first_v   [2] = '{-1, -1};
   int          xfers     [2] = '{0, 0};
   int          sols      [2] = '{0, 0};
   int          lasts     [2] = '{0, 0};
   logic [63:0] last_data [2] = '{64'h0, 64'h0};
   int          last_cyc  [2] = '{-1, -1};

   task automatic clear_stats(input int d);
      first_v[d]   = -1;
      xfers[d]     = 0;
      sols[d]      = 0;
      lasts[d]     = 0;
      last_data[d] = '0;
      last_cyc[d]  = -1;
   endtask

   task automatic mon(input int d, input logic rstn, input logic valid, input logic ready,
                      input logic [63:0] data, input int idx, input logic sol, input logic last);
      if (!rstn) begin
         exp_idx[d] = 0;
         stalled[d] = 0;
         return;
      end
      if (stalled[d]) begin
         chk($sformatf("hold_valid%0d", d), valid, 1'b1);
         chk($sformatf("hold_data%0d", d), data, hold_data[d]);
         chk($sformatf("hold_idx%0d", d), idx, hold_idx[d]);
      end
      if (valid === 1'b1) begin
         if (first_v[d] < 0) first_v[d] = cyc[d];
         chk($sformatf("data%0d", d), data, base[d] + 64'(exp_idx[d]));
         chk($sformatf("idx%0d", d), idx, exp_idx[d]);
         chk($sformatf("sol%0d", d), sol, (exp_idx[d] % grp[d]) == 0);
         chk($sformatf("last%0d", d), last, exp_idx[d] == nregs[d] - 1);
         if (ready === 1'b1) begin
            $display("xfer dut%0d cyc=%0d idx=%0d data=%h sol=%0b last=%0b",
                     d, cyc[d], idx, data, sol, last);
            xfers[d]++;
            if (sol) sols[d]++;
            if (last) begin
               lasts[d]++;
               last_data[d] = data;
               last_cyc[d]  = cyc[d];
            end
            exp_idx[d] = (exp_idx[d] == nregs[d] - 1) ? 0 : exp_idx[d] + 1;
         end
      end
      stalled[d]   = (valid === 1'b1) && (ready !== 1'b1);
      hold_data[d] = data;
      hold_idx[d]  = idx;
   endtask

   always @(negedge clk) begin
      mon(0, rst_a, ifa.valid, ifa.ready, 64'(ifa.data), int'(ifa.idx), ifa.sol, ifa.last);
      mon(1, rst_b, ifb.valid, ifb.ready, ifb.data, int'(ifb.idx), ifb.sol, ifb.last);
   end

   task automatic tick(input int n = 1);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   int c0;

   initial begin
      rst_a = 0; rst_b = 0;
      halt_a = 0; halt_b = 0;
      rearm_a = 0; rearm_b = 0;
      ifa.ready = 1; ifb.ready = 1;
      tick(3);

      // Reset values
      chk("rst_valid_a", ifa.valid, 1'b0);
      chk("rst_data_a", ifa.data, 32'h0);
      chk("rst_rfaddr_a", rf_addr_a, 5'd0);
      chk("rst_flags_a", {ifa.sol, ifa.last, busy_a, done_a}, 4'b0000);
      chk("rst_idx_a", ifa.idx, 5'd0);
      chk("rst_valid_b", ifb.valid, 1'b0);
      chk("rst_data_b", ifb.data, 64'h0);
      rst_a = 1; rst_b = 1;

      // Timeout-triggered dump, sink always ready
      for (int n = 0; n < 300 && !done_a; n++) tick();
      chk("to_done", done_a, 1'b1);
      chk("to_busy", busy_a, 1'b0);
      chk("to_first_cycle", first_v[0], 22);
      chk("to_words", xfers[0], 32);
      chk("to_sol_count", sols[0], 4);
      chk("to_last_count", lasts[0], 1);
      chk("to_last_data", last_data[0], 64'hA000_001F);
      chk("to_last_cycle", last_cyc[0], 84);

      // Halt ignored while done
      halt_a = 1;
      tick(5);
      chk("done_halt_ign", done_a, 1'b1);
      chk("done_no_words", xfers[0], 32);
      halt_a = 0;

      // Re-arm; halt rises on the cycle the timer hits; random backpressure
      clear_stats(0);
      rearm_a = 1;
      c0 = cyc[0];
      tick();
      rearm_a = 0;
      while (cyc[0] < c0 + 20) tick();
      chk("sim_not_early", busy_a, 1'b0);
      halt_a = 1;
      for (int n = 0; n < 1000 && !done_a; n++) begin
         ifa.ready = ($urandom_range(0, 99) >= 30);
         tick();
      end
      halt_a = 0;
      ifa.ready = 1;
      chk("bp_done", done_a, 1'b1);
      chk("bp_first_cycle", first_v[0], c0 + 22);
      chk("bp_words", xfers[0], 32);
      chk("bp_sol_count", sols[0], 4);
      chk("bp_last_count", lasts[0], 1);
      tick(3);
      chk("bp_single_scan", xfers[0], 32);

      // Asynchronous reset in the middle of a scan
      rearm_a = 1;
      tick();
      rearm_a = 0;
      halt_a = 1;
      tick();
      halt_a = 0;
      begin
         int n = 0;
         while (!(ifa.valid === 1'b1 && ifa.idx == 5'd13) && n < 200) begin
            tick();
            n++;
         end
         chk("mid_reach_13", ifa.idx, 5'd13);
      end
      #2 rst_a = 0;
      #1;
      chk("mid_valid_drop", ifa.valid, 1'b0);
      chk("mid_busy_drop", busy_a, 1'b0);
      chk("mid_data_clr", ifa.data, 32'h0);
      tick(2);
      rst_a = 1;
      clear_stats(0);
      for (int n = 0; n < 300 && !done_a; n++) tick();
      chk("mid_redump_done", done_a, 1'b1);
      chk("mid_redump_first", first_v[0], 22);
      chk("mid_redump_words", xfers[0], 32);

      // Halt-triggered dump on the 20x64 instance with the timer disabled
      rst_b = 0;
      tick(2);
      rst_b = 1;
      clear_stats(1);
      while (cyc[1] < 5) tick();
      halt_b = 1;
      for (int n = 0; n < 300 && !done_b; n++) tick();
      chk("h_done", done_b, 1'b1);
      chk("h_first_cycle", first_v[1], 7);
      chk("h_words", xfers[1], 20);
      chk("h_sol_count", sols[1], 4);
      chk("h_last_count", lasts[1], 1);
      chk("h_last_data", last_data[1], 64'hC0DE_F00D_A000_0013);
      chk("h_last_cycle", last_cyc[1], 45);
      halt_b = 0;
      rearm_b = 1;
      tick();
      rearm_b = 0;
      tick(1000);
      chk("h_no_second", xfers[1], 20);
      chk("h_rearm_busy", busy_b, 1'b0);
      chk("h_rearm_armed", done_b, 1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
